// File: rtl/oam_dma_master_if.sv
// Handshake and address/strobe bundle between the OAM DMA initiator and the
// system side (start control, arbiter grant, memory strobes).
interface oam_dma_master_if;
  logic        START;
  logic [7:0]  SRC_PAGE;
  logic        BUS_GRANT;
  logic        BUS_REQ;
  logic        BUSY;
  logic        DONE;
  logic        MREQ;
  logic        RD;
  logic        WR;
  logic [15:0] A;

  modport master (
    input  START, SRC_PAGE, BUS_GRANT,
    output BUS_REQ, BUSY, DONE, MREQ, RD, WR, A
  );

  modport slave (
    output START, SRC_PAGE, BUS_GRANT,
    input  BUS_REQ, BUSY, DONE, MREQ, RD, WR, A
  );
endinterface

// File: rtl/oam_dma_master.sv
// SM83-bus OAM DMA initiator: copies LEN bytes from SRC_PAGE:00 to DST_BASE.
// Optional macro DMA_ECHO_MIRROR_EN folds echo-RAM source pages E0-FF onto C0-DF.
module oam_dma_master #(
  parameter logic [15:0] DST_BASE = 16'hFE00,
  parameter int unsigned LEN      = 160
) (
  input  logic             CLK,
  input  logic             RESET,
  oam_dma_master_if.master bus,
  inout  wire  [7:0]       D
);
  localparam logic [8:0] LAST = 9'(LEN - 1);

  typedef enum logic [2:0] {IDLE, REQ, RD_A, RD_S, WR_A, WR_S} state_t;

  state_t      state, state_nxt;
  logic [7:0]  page, page_nxt;
  logic [8:0]  idx, idx_nxt;
  logic [7:0]  latch;
  logic        done_nxt, mreq_nxt, rd_nxt, wr_nxt, oe_nxt, busy_nxt;
  logic [15:0] a_nxt;
  logic        busy_q, done_q, mreq_q, rd_q, wr_q, oe_q;
  logic [15:0] a_q;

  function automatic logic [7:0] map_page(input logic [7:0] p);
`ifdef DMA_ECHO_MIRROR_EN
    return (p >= 8'hE0) ? p - 8'h20 : p;
`else
    return p;
`endif
  endfunction

  // A START always wins, so a restart coinciding with the final write suppresses DONE.
  always_comb begin
    state_nxt = state;
    page_nxt  = page;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    if (bus.START) begin
      page_nxt  = map_page(bus.SRC_PAGE);
      idx_nxt   = 9'd0;
      state_nxt = (state != IDLE && bus.BUS_GRANT) ? RD_A : REQ;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        REQ:  state_nxt = bus.BUS_GRANT ? RD_A : REQ;
        RD_A: state_nxt = bus.BUS_GRANT ? RD_S : REQ;
        RD_S: state_nxt = bus.BUS_GRANT ? WR_A : REQ;
        WR_A: state_nxt = bus.BUS_GRANT ? WR_S : REQ;
        WR_S: begin
          if (!bus.BUS_GRANT) begin
            state_nxt = REQ;
          end else begin
            idx_nxt = idx + 9'd1;
            if (idx == LAST) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = RD_A;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they leave a register.
    mreq_nxt = (state_nxt == RD_A) || (state_nxt == RD_S) ||
               (state_nxt == WR_A) || (state_nxt == WR_S);
    rd_nxt   = (state_nxt == RD_A) || (state_nxt == RD_S);
    wr_nxt   = (state_nxt == WR_S);
    oe_nxt   = (state_nxt == WR_A) || (state_nxt == WR_S);
    busy_nxt = (state_nxt != IDLE);
    a_nxt    = 16'h0000;
    if (rd_nxt) begin
      a_nxt = {page_nxt, 8'h00} + {7'b0, idx_nxt};
    end else if (mreq_nxt) begin
      a_nxt = DST_BASE + {7'b0, idx_nxt};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      page   <= 8'h00;
      idx    <= 9'd0;
      latch  <= 8'h00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mreq_q <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      oe_q   <= 1'b0;
      a_q    <= 16'h0000;
    end else begin
      state  <= state_nxt;
      page   <= page_nxt;
      idx    <= idx_nxt;
      if (state == RD_S && state_nxt == WR_A) begin
        latch <= D;
      end
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      mreq_q <= mreq_nxt;
      rd_q   <= rd_nxt;
      wr_q   <= wr_nxt;
      oe_q   <= oe_nxt;
      a_q    <= a_nxt;
    end
  end

  assign D           = oe_q ? latch : 8'hzz;
  assign bus.BUS_REQ = busy_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.MREQ    = mreq_q;
  assign bus.RD      = rd_q;
  assign bus.WR      = wr_q;
  assign bus.A       = a_q;
endmodule

// File: tb/tb_oam_dma_master.sv
// Directed/randomised bench for oam_dma_master with a flat memory responder
// and a byte-copy reference model built from the source memory image.
module tb_oam_dma_master;
  localparam int          LEN = 160;
  localparam logic [15:0] DST = 16'hFE00;

  logic CLK = 1'b0;
  logic RESET;
  oam_dma_master_if bus();
  wire  [7:0] d_bus;

  logic [7:0] rom  [0:65535];
  logic [7:0] wmem [0:65535];
  logic [7:0] ref_img [0:LEN-1];
  logic [7:0] old_img [0:LEN-1];

  int total = 0;
  int bad = 0;
  int done_pulses = 0;
  int wr_strobes = 0;
  int c005_reads = 0;

  always #5 CLK = ~CLK;

  oam_dma_master #(.DST_BASE(DST), .LEN(LEN)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .D(d_bus)
  );

  // Memory responder: sources read data from rom, captures writes into wmem.
  assign d_bus = (bus.MREQ && bus.RD) ? rom[bus.A] : 8'hzz;

  always @(posedge CLK) begin
    if (bus.MREQ && bus.WR) begin
      wmem[bus.A] <= d_bus;
      wr_strobes  <= wr_strobes + 1;
    end
    if (bus.MREQ && bus.RD && bus.A == 16'hC005) c005_reads <= c005_reads + 1;
    if (bus.DONE) done_pulses <= done_pulses + 1;
  end

  function automatic logic [7:0] src_of(input logic [7:0] p);
`ifdef DMA_ECHO_MIRROR_EN
    if (p >= 8'hE0) return p - 8'h20;
`endif
    return p;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic build_ref(input logic [7:0] page);
    for (int k = 0; k < LEN; k++) ref_img[k] = rom[(int'(src_of(page)) * 256 + k) % 65536];
  endtask

  task automatic check_image(input string tag, input int first);
    for (int k = first; k < LEN; k++) begin
      logic [15:0] addr;
      addr = DST + 16'(k);
      check_output($sformatf("%s[%0d]", tag, k), {24'b0, wmem[addr]}, {24'b0, ref_img[k]});
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_bus_req"}, {31'b0, bus.BUS_REQ}, 0);
    check_output({tag, "_busy"},    {31'b0, bus.BUSY},    0);
    check_output({tag, "_done"},    {31'b0, bus.DONE},    0);
    check_output({tag, "_mreq"},    {31'b0, bus.MREQ},    0);
    check_output({tag, "_rd"},      {31'b0, bus.RD},      0);
    check_output({tag, "_wr"},      {31'b0, bus.WR},      0);
    check_output({tag, "_addr"},    {16'b0, bus.A},       0);
  endtask

  // Pulses START for one cycle; returns at the negedge after the sampling edge.
  task automatic apply_stimulus(input logic [7:0] page);
    @(negedge CLK);
    bus.SRC_PAGE = page;
    bus.START    = 1'b1;
    @(negedge CLK);
    bus.START    = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!bus.DONE && lat < 3000) begin
      @(negedge CLK);
      lat++;
    end
    if (!bus.DONE) begin
      total++;
      bad++;
      $error("[TB] FAIL %s_timeout: observed=no DONE expected=DONE within 3000 cycles", tag);
    end
  endtask

  task automatic wait_addr(input string tag, input logic [15:0] addr, input logic rd);
    int n;
    n = 0;
    while (!(bus.MREQ && bus.RD === rd && !bus.WR && bus.A === addr) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $error("[TB] FAIL %s_timeout: observed=no cycle expected=A=%h", tag, addr);
    end
  endtask

  initial begin
    int lat, w0, d0, r0, strobes;
    logic [7:0] rpage;
    logic [15:0] first_a;

    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) rom[16'hC000 + i] = 8'(i);
    rom[16'hC100] = 8'h5A;
    rom[16'hE100] = 8'hA5;

    RESET = 1'b1;
    bus.START = 1'b0;
    bus.SRC_PAGE = 8'h00;
    bus.BUS_GRANT = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    RESET = 1'b0;
    $display("[TB] basic copy");

    build_ref(8'hC0);
    apply_stimulus(8'hC0);
    check_output("start_busy", {31'b0, bus.BUSY}, 1);
    check_output("start_req", {31'b0, bus.BUS_REQ}, 1);
    wait_done("basic", lat);
    check_output("basic_latency", lat, 641);
    check_output("basic_done_busy", {31'b0, bus.BUSY}, 0);
    check_output("basic_done_req", {31'b0, bus.BUS_REQ}, 0);
    strobes = 0;
    repeat (5) begin
      @(negedge CLK);
      if (bus.MREQ || bus.RD || bus.WR || bus.DONE) strobes++;
    end
    check_output("basic_quiet_after_done", strobes, 0);
    check_image("basic_img", 0);

    $display("[TB] random page copy");
    rpage = 8'($urandom_range(8'h01, 8'hBF));
    build_ref(rpage);
    w0 = wr_strobes;
    apply_stimulus(rpage);
    wait_done("random", lat);
    check_output("random_latency", lat, 641);
    @(negedge CLK);
    check_output("random_writes", wr_strobes - w0, LEN);
    check_image("random_img", 0);

    $display("[TB] grant handshake");
    bus.BUS_GRANT = 1'b0;
    build_ref(8'hC0);
    apply_stimulus(8'hC0);
    for (int i = 0; i < 10; i++) begin
      check_output($sformatf("wait_req_%0d", i), {31'b0, bus.BUS_REQ}, 1);
      check_output($sformatf("wait_busy_%0d", i), {31'b0, bus.BUSY}, 1);
      check_output($sformatf("wait_mreq_%0d", i), {31'b0, bus.MREQ}, 0);
      @(negedge CLK);
    end
    bus.BUS_GRANT = 1'b1;
    @(negedge CLK);
    check_output("grant_first_mreq", {31'b0, bus.MREQ}, 1);
    check_output("grant_first_rd", {31'b0, bus.RD}, 1);
    check_output("grant_first_addr", {16'b0, bus.A}, 32'hC000);
    wait_done("grant", lat);
    @(negedge CLK);
    check_image("grant_img", 0);

    $display("[TB] grant drop at byte 5");
    r0 = c005_reads;
    w0 = wr_strobes;
    apply_stimulus(8'hC0);
    wait_addr("drop_find", DST + 16'd5, 1'b0);
    check_output("drop_wdata", {24'b0, d_bus}, 32'h05);
    bus.BUS_GRANT = 1'b0;
    @(negedge CLK);
    check_output("drop_mreq", {31'b0, bus.MREQ}, 0);
    check_output("drop_rd", {31'b0, bus.RD}, 0);
    check_output("drop_wr", {31'b0, bus.WR}, 0);
    check_output("drop_req", {31'b0, bus.BUS_REQ}, 1);
    repeat (2) @(negedge CLK);
    bus.BUS_GRANT = 1'b1;
    wait_done("drop", lat);
    @(negedge CLK);
    check_output("drop_c005_read_cycles", c005_reads - r0, 4);
    check_output("drop_writes", wr_strobes - w0, LEN);
    check_image("drop_img", 0);

    $display("[TB] restart at byte 40");
    for (int i = 0; i < 256; i++) rom[16'hD000 + i] = 8'($urandom);
    d0 = done_pulses;
    apply_stimulus(8'hC0);
    wait_addr("restart_find", 16'hC028, 1'b1);
    bus.SRC_PAGE = 8'hD0;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    wait_done("restart", lat);
    // Restart with grant present skips REQ, so one cycle shorter than a cold start.
    check_output("restart_latency", lat, 640);
    repeat (3) @(negedge CLK);
    check_output("restart_done_count", done_pulses - d0, 1);
    build_ref(8'hD0);
    check_image("restart_img", 0);
    for (int k = 0; k < LEN; k++) old_img[k] = ref_img[k];

    $display("[TB] reset at byte 20");
    apply_stimulus(8'hC0);
    wait_addr("reset_find", 16'hC014, 1'b1);
    RESET = 1'b1;
    @(negedge CLK);
    check_reset_values("midreset");
    RESET = 1'b0;
    w0 = wr_strobes;
    repeat (30) @(negedge CLK);
    check_output("midreset_no_writes", wr_strobes - w0, 0);
    check_output("midreset_idle", {31'b0, bus.BUSY}, 0);
    for (int k = 0; k < LEN; k++) ref_img[k] = old_img[k];
    check_image("midreset_img", 20);

    $display("[TB] echo page");
    apply_stimulus(8'hE1);
    lat = 0;
    while (!(bus.MREQ && bus.RD) && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
    first_a = bus.A;
`ifdef DMA_ECHO_MIRROR_EN
    check_output("echo_addr", {16'b0, first_a}, 32'hC100);
`else
    check_output("echo_addr", {16'b0, first_a}, 32'hE100);
`endif
    wait_done("echo", lat);
    @(negedge CLK);
    build_ref(8'hE1);
    check_image("echo_img", 0);
`ifdef DMA_ECHO_MIRROR_EN
    check_output("echo_fe00", {24'b0, wmem[16'hFE00]}, 32'h5A);
`else
    check_output("echo_fe00", {24'b0, wmem[16'hFE00]}, 32'hA5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
